// File: rtl/ocpapb_fifo.sv
// +----------------------------------------------------------------------------+
// | ocpapb_fifo                                                                |
// | APB-push / OCP-pop byte FIFO with occupancy, sticky overflow and flush.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ocpapb_fifo #(
  parameter int APB_ADDR_WIDTH  = 32,
  parameter int OCP_ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 256,
  parameter int FIFO_DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [APB_ADDR_WIDTH-1:0] apb_paddr,
  input  logic                      apb_psel,
  input  logic                      apb_penable,
  input  logic                      apb_pwrite,
  input  logic [DATA_WIDTH-1:0]     apb_pwdata,
  output logic [DATA_WIDTH-1:0]     apb_prdata,
  output logic                      apb_pready,
  input  logic [OCP_ADDR_WIDTH-1:0] ocp_maddr,
  input  logic [2:0]                ocp_mcmd,
  input  logic [DATA_WIDTH-1:0]     ocp_mdata,
  input  logic [DATA_WIDTH/8-1:0]   ocp_mbyteen,
  output logic                      ocp_scmdaccept,
  output logic [DATA_WIDTH-1:0]     ocp_sdata,
  output logic [1:0]                ocp_sresp
);

  localparam int unsigned    c_AW        = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0]  c_FULL      = (c_AW + 1)'(FIFO_DEPTH);
  localparam logic [2:0]     c_CMD_IDLE  = 3'd0;
  localparam logic [2:0]     c_CMD_READ  = 3'd2;
  localparam logic [1:0]     c_RESP_NULL = 2'd0;
  localparam logic [1:0]     c_RESP_DVA  = 2'd1;

  typedef enum logic [0:0] {
    S_SETUP  = 1'b0,
    S_ENABLE = 1'b1
  } apb_state_t;

  apb_state_t                 r_apb_state;
  logic                       r_pready;
  logic [DATA_WIDTH-1:0]      r_prdata;
  logic [DATA_WIDTH-1:0]      r_sdata;
  logic [1:0]                 r_sresp;
  logic [FIFO_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]            r_wr_ptr;
  logic [c_AW-1:0]            r_rd_ptr;
  logic [c_AW:0]              r_count;
  logic                       r_ovf;

  logic                  w_empty;
  logic                  w_full;
  logic [31:0]           w_status;
  logic                  w_apb_commit;
  logic                  w_apb_fifo_wr;
  logic                  w_apb_ctrl_wr;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_ovf_clr;
  logic [DATA_WIDTH-1:0] w_prdata_nxt;
  logic [DATA_WIDTH-1:0] w_sdata_nxt;
  logic                  w_unused;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_FULL);
  assign w_status = {w_empty, w_full, r_ovf, 12'b0, {(16 - c_AW){1'b0}}, r_count};

  assign w_apb_commit  = (r_apb_state == S_ENABLE) && apb_psel && apb_penable;
  assign w_apb_fifo_wr = w_apb_commit && apb_pwrite && (apb_paddr == '0);
  assign w_apb_ctrl_wr = w_apb_commit && apb_pwrite && (apb_paddr == APB_ADDR_WIDTH'(4));
  assign w_push        = w_apb_fifo_wr && !w_full;
  assign w_drop        = w_apb_fifo_wr && w_full;
  assign w_flush       = w_apb_ctrl_wr && apb_pwdata[1];
  assign w_ovf_clr     = w_apb_ctrl_wr && apb_pwdata[0];
  assign w_pop         = (ocp_mcmd == c_CMD_READ) && (ocp_maddr == '0) && !w_empty;

  always_comb begin
    w_prdata_nxt = '1;
    if (apb_paddr == '0)
      w_prdata_nxt = w_status;
    else if (apb_paddr == APB_ADDR_WIDTH'(4))
      w_prdata_nxt = '0;
  end

  // Pop data reads the pre-edge rd_ptr, so a same-cycle flush cannot disturb it.
  always_comb begin
    w_sdata_nxt = '0;
    if (ocp_mcmd == c_CMD_READ) begin
      if (ocp_maddr == '0) begin
        if (w_empty)
          w_sdata_nxt = {1'b1, 31'b0};
        else
          w_sdata_nxt = {1'b0, w_full, {(30 - FIFO_DATA_WIDTH){1'b0}}, r_mem[r_rd_ptr]};
      end else if (ocp_maddr == OCP_ADDR_WIDTH'(4)) begin
        w_sdata_nxt = w_status;
      end else begin
        w_sdata_nxt = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_apb_state <= S_SETUP;
      r_pready    <= 1'b0;
      r_prdata    <= '0;
    end else begin
      case (r_apb_state)
        S_SETUP: begin
          r_pready <= 1'b0;
          if (apb_psel && apb_penable)
            r_apb_state <= S_ENABLE;
        end
        S_ENABLE: begin
          r_apb_state <= S_SETUP;
          r_pready    <= w_apb_commit;
          if (w_apb_commit && !apb_pwrite)
            r_prdata <= w_prdata_nxt;
        end
        default: begin
          r_apb_state <= S_SETUP;
          r_pready    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push)
          r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
      if (w_ovf_clr)
        r_ovf <= 1'b0;
      else if (w_drop)
        r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst)
      r_mem[r_wr_ptr] <= apb_pwdata[FIFO_DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sdata <= '0;
      r_sresp <= c_RESP_NULL;
    end else begin
      r_sdata <= w_sdata_nxt;
      r_sresp <= (ocp_mcmd != c_CMD_IDLE) ? c_RESP_DVA : c_RESP_NULL;
    end
  end

  assign apb_prdata     = r_prdata;
  assign apb_pready     = r_pready;
  assign ocp_sdata      = r_sdata;
  assign ocp_sresp      = r_sresp;
  assign ocp_scmdaccept = 1'b1;

  assign w_unused = &{1'b0, ocp_mdata, ocp_mbyteen, apb_pwdata[DATA_WIDTH-1:FIFO_DATA_WIDTH]};

endmodule

`default_nettype wire

// File: tb/tb_ocpapb_fifo.sv
// +----------------------------------------------------------------------------+
// | tb_ocpapb_fifo                                                             |
// | Self-checking bench: vector table, corner sequences, random vs queue model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ocpapb_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] apb_paddr, apb_pwdata, apb_prdata;
  logic        apb_psel, apb_penable, apb_pwrite, apb_pready;
  logic [31:0] ocp_maddr, ocp_mdata, ocp_sdata;
  logic [2:0]  ocp_mcmd;
  logic [3:0]  ocp_mbyteen;
  logic        ocp_scmdaccept;
  logic [1:0]  ocp_sresp;

  int total = 0;
  int bad   = 0;

  ocpapb_fifo dut (
    .clk(clk), .rst(rst),
    .apb_paddr(apb_paddr), .apb_psel(apb_psel), .apb_penable(apb_penable),
    .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
    .apb_pready(apb_pready),
    .ocp_maddr(ocp_maddr), .ocp_mcmd(ocp_mcmd), .ocp_mdata(ocp_mdata),
    .ocp_mbyteen(ocp_mbyteen), .ocp_scmdaccept(ocp_scmdaccept),
    .ocp_sdata(ocp_sdata), .ocp_sresp(ocp_sresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 APB write, 1 APB read, 2 OCP command
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int k, logic [2:0] c, logic [31:0] a, logic [31:0] w,
                              logic [31:0] e, string nm);
    vec_t v;
    v.kind = k; v.cmd = c; v.addr = a; v.wdata = w; v.exp = e; v.name = nm;
    return v;
  endfunction

  function automatic logic [31:0] status_word(int n, bit o);
    return {(n == 0), (n == 256), o, 29'(n)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd);
    int n;
    @(negedge clk);
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = wr; apb_paddr = addr; apb_pwdata = wd;
    @(negedge clk);
    apb_penable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!apb_pready && n < 8);
    check("apb_pready_latency", 32'(n), 32'd2);
    rd = apb_prdata;
    apb_psel = 1'b0; apb_penable = 1'b0;
    @(negedge clk);
    check("apb_pready_pulse", {31'b0, apb_pready}, 32'd0);
  endtask

  task automatic ocp(input logic [2:0] cmd, input logic [31:0] addr, output logic [31:0] d);
    @(negedge clk);
    ocp_mcmd = cmd; ocp_maddr = addr;
    @(negedge clk);
    check("ocp_sresp", {30'b0, ocp_sresp}, (cmd != 3'd0) ? 32'd1 : 32'd0);
    d = ocp_sdata;
    ocp_mcmd = 3'd0;
  endtask

  logic [31:0] d;
  logic [7:0]  q[$];
  bit          ovf_m;

  initial begin
    rst = 1'b1;
    apb_paddr = '0; apb_pwdata = '0; apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
    ocp_maddr = '0; ocp_mdata = 32'hDEAD_BEEF; ocp_mbyteen = 4'hF; ocp_mcmd = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_pready", {31'b0, apb_pready}, 32'd0);
    check("reset_prdata", apb_prdata, 32'd0);
    check("reset_sdata", ocp_sdata, 32'd0);
    check("reset_sresp", {30'b0, ocp_sresp}, 32'd0);
    check("scmdaccept", {31'b0, ocp_scmdaccept}, 32'd1);
    rst = 1'b0;

    vecs.push_back(mk(2, 3'd2, 32'h0, 32'h0, 32'h8000_0000, "ocp_pop_empty"));
    vecs.push_back(mk(1, 3'd0, 32'h0, 32'h0, 32'h8000_0000, "apb_status_empty"));
    vecs.push_back(mk(1, 3'd0, 32'h4, 32'h0, 32'h0000_0000, "apb_read_ctrl"));
    vecs.push_back(mk(1, 3'd0, 32'h8, 32'h0, 32'hFFFF_FFFF, "apb_read_other"));
    vecs.push_back(mk(0, 3'd0, 32'h0, 32'h11, 32'h0, "push"));
    vecs.push_back(mk(0, 3'd0, 32'h0, 32'h22, 32'h0, "push"));
    vecs.push_back(mk(0, 3'd0, 32'h0, 32'hABCD_0133, 32'h0, "push"));
    vecs.push_back(mk(0, 3'd0, 32'hC, 32'h99, 32'h0, "write_other"));
    vecs.push_back(mk(2, 3'd2, 32'h4, 32'h0, 32'h0000_0003, "ocp_status_3"));
    vecs.push_back(mk(1, 3'd0, 32'h0, 32'h0, 32'h0000_0003, "apb_status_3"));
    vecs.push_back(mk(2, 3'd2, 32'h0, 32'h0, 32'h0000_0011, "pop_11"));
    vecs.push_back(mk(2, 3'd2, 32'h0, 32'h0, 32'h0000_0022, "pop_22"));
    vecs.push_back(mk(2, 3'd2, 32'h0, 32'h0, 32'h0000_0033, "pop_33"));
    vecs.push_back(mk(2, 3'd2, 32'h0, 32'h0, 32'h8000_0000, "pop_empty_again"));
    vecs.push_back(mk(2, 3'd2, 32'h10, 32'h0, 32'hFFFF_FFFF, "ocp_read_other"));
    vecs.push_back(mk(2, 3'd1, 32'h0, 32'h0, 32'h0000_0000, "ocp_write"));
    vecs.push_back(mk(2, 3'd5, 32'h0, 32'h0, 32'h0000_0000, "ocp_cmd5"));
    vecs.push_back(mk(2, 3'd2, 32'h4, 32'h0, 32'h8000_0000, "ocp_status_empty"));

    foreach (vecs[i]) begin
      case (vecs[i].kind)
        0: apb(1'b1, vecs[i].addr, vecs[i].wdata, d);
        1: begin apb(1'b0, vecs[i].addr, 32'h0, d); check(vecs[i].name, d, vecs[i].exp); end
        default: begin ocp(vecs[i].cmd, vecs[i].addr, d); check(vecs[i].name, d, vecs[i].exp); end
      endcase
    end

    // The cycle after a command with IDLE on the bus gives NULL with zero data.
    ocp(3'd2, 32'h4, d);
    @(negedge clk);
    check("idle_sresp", {30'b0, ocp_sresp}, 32'd0);
    check("idle_sdata", ocp_sdata, 32'd0);

    for (int i = 0; i < 256; i++) apb(1'b1, 32'h0, 32'(i), d);
    ocp(3'd2, 32'h4, d);       check("full_status", d, 32'h4000_0100);
    apb(1'b1, 32'h0, 32'hEE, d);
    apb(1'b0, 32'h0, 32'h0, d); check("ovf_status", d, 32'h6000_0100);
    apb(1'b1, 32'h4, 32'h1, d);
    ocp(3'd2, 32'h4, d);       check("ovf_cleared", d, 32'h4000_0100);

    // Full: APB push committing on the same edge as an OCP pop.
    @(negedge clk);
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b1; apb_paddr = 32'h0; apb_pwdata = 32'hAA;
    @(negedge clk); apb_penable = 1'b1;
    @(negedge clk); ocp_mcmd = 3'd2; ocp_maddr = 32'h0;
    @(negedge clk);
    check("same_cycle_pready", {31'b0, apb_pready}, 32'd1);
    check("same_cycle_pop", ocp_sdata, 32'h4000_0000);
    apb_psel = 1'b0; apb_penable = 1'b0; ocp_mcmd = 3'd0;
    ocp(3'd2, 32'h4, d);       check("same_cycle_status", d, 32'h2000_00FF);
    ocp(3'd2, 32'h0, d);       check("pop_after_full", d, 32'h0000_0001);
    apb(1'b1, 32'h4, 32'h3, d);
    ocp(3'd2, 32'h4, d);       check("clear_flush", d, 32'h8000_0000);

    for (int i = 0; i < 5; i++) apb(1'b1, 32'h0, 32'(8'h50 + i), d);
    ocp(3'd2, 32'h4, d);       check("five_queued", d, 32'h0000_0005);
    apb(1'b1, 32'h4, 32'h2, d);
    ocp(3'd2, 32'h4, d);       check("flush_status", d, 32'h8000_0000);
    ocp(3'd2, 32'h0, d);       check("flush_pop", d, 32'h8000_0000);

    // Reset while an APB write and an OCP read are in flight.
    apb(1'b1, 32'h0, 32'h77, d);
    apb(1'b0, 32'h0, 32'h0, d); check("pre_reset_status", d, 32'h0000_0001);
    @(negedge clk);
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b1; apb_paddr = 32'h0; apb_pwdata = 32'h55;
    @(negedge clk); apb_penable = 1'b1; ocp_mcmd = 3'd2; ocp_maddr = 32'h4;
    @(negedge clk); rst = 1'b1;
    check("pre_reset_sresp", {30'b0, ocp_sresp}, 32'd1);
    @(negedge clk);
    check("midrst_pready", {31'b0, apb_pready}, 32'd0);
    check("midrst_prdata", apb_prdata, 32'd0);
    check("midrst_sdata", ocp_sdata, 32'd0);
    check("midrst_sresp", {30'b0, ocp_sresp}, 32'd0);
    rst = 1'b0; apb_psel = 1'b0; apb_penable = 1'b0; ocp_mcmd = 3'd0;
    ocp(3'd2, 32'h4, d);       check("post_reset_status", d, 32'h8000_0000);

    // Randomized interleaving against a queue model.
    q.delete();
    ovf_m = 1'b0;
    begin
      int pushed = 0;
      int steps  = 0;
      while (pushed < 600 && steps < 4000) begin
        int r;
        logic [7:0] b;
        logic [31:0] e;
        steps++;
        r = $urandom_range(0, 99);
        if (r < 62) begin
          b = 8'($urandom);
          apb(1'b1, 32'h0, {24'($urandom), b}, d);
          if (q.size() < 256) begin q.push_back(b); pushed++; end
          else ovf_m = 1'b1;
        end else if (r < 94) begin
          ocp(3'd2, 32'h0, d);
          if (q.size() == 0) e = 32'h8000_0000;
          else begin
            e = {1'b0, (q.size() == 256), 22'b0, q[0]};
            void'(q.pop_front());
          end
          check("rand_pop", d, e);
        end else begin
          ocp(3'd2, 32'h4, d);
          check("rand_status", d, status_word(q.size(), ovf_m));
        end
      end
      check("rand_push_budget", 32'(pushed), 32'd600);
      while (q.size() > 0) begin
        logic [31:0] e;
        e = {1'b0, (q.size() == 256), 22'b0, q[0]};
        void'(q.pop_front());
        ocp(3'd2, 32'h0, d);
        check("drain_pop", d, e);
      end
      ocp(3'd2, 32'h4, d);
      check("drain_status", d, status_word(0, ovf_m));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ocpapb_fifo.md
# ocpapb_fifo

APB-to-OCP byte FIFO: the APB side (peripheral bus master) pushes bytes, and the OCP side (CPU/OCP master) pops them. It is the transmit-direction counterpart of the existing OCP-to-APB FIFO. It sits between the APB peripheral fabric and the OCP interconnect as a slave on both buses, and adds occupancy, overflow and flush control.

## Interface
- APB_ADDR_WIDTH, 32, APB address width
- OCP_ADDR_WIDTH, 32, OCP address width
- DATA_WIDTH, 32, data width on both buses; only 32 is supported
- FIFO_DEPTH, 256, number of entries; power of two, 2..32768
- FIFO_DATA_WIDTH, 8, entry width; must not exceed 29
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  reset; synchronous, active-high
- apb_paddr  in  APB_ADDR_WIDTH  APB address
- apb_psel  in  1  APB select
- apb_penable  in  1  APB enable
- apb_pwrite  in  1  1 = write
- apb_pwdata  in  DATA_WIDTH  APB write data
- apb_prdata  out  DATA_WIDTH  APB read data, registered
- apb_pready  out  1  transfer complete, registered one-cycle pulse
- ocp_maddr  in  OCP_ADDR_WIDTH  OCP address
- ocp_mcmd  in  3  0 IDLE, 1 WRITE, 2 READ
- ocp_mdata  in  DATA_WIDTH  ignored
- ocp_mbyteen  in  DATA_WIDTH/8  ignored
- ocp_scmdaccept  out  1  tied to 1
- ocp_sdata  out  DATA_WIDTH  OCP read data, registered
- ocp_sresp  out  2  0 NULL, 1 DVA

## Operation
- Storage is FIFO_DEPTH×FIFO_DATA_WIDTH memory with wr_ptr and rd_ptr, each log2(FIFO_DEPTH) bits, wrapping naturally.
- count is log2(FIFO_DEPTH)+1 bits, 0..FIFO_DEPTH. empty = (count==0); full = (count==FIFO_DEPTH).
- ovf is a sticky overflow flag.
- STATUS word = {empty, full, ovf, zeros, count zero-extended to bits[16:0]}.
- APB FSM has two states:
  - SETUP: apb_pready<=0. If psel&&penable, go to ENABLE.
  - ENABLE: if psel&&penable, then apb_pready<=1, perform the access, and return to SETUP. Otherwise return to SETUP with no access.
- APB write, paddr==0: if !full, push pwdata[FIFO_DATA_WIDTH-1:0]. If full, drop the data and set ovf.
- APB write, paddr==4:
  - pwdata[0]=1 clears ovf.
  - pwdata[1]=1 flushes: wr_ptr=rd_ptr=count=0.
- APB write, other addresses: ignored.
- APB read: paddr==0 returns STATUS; paddr==4 returns 0; any other address returns all ones. apb_prdata is held until the next read access.
- OCP: any mcmd!=IDLE produces sresp=DVA in the next cycle. The cycle after an IDLE gives sresp=NULL and sdata=0.
- OCP READ, maddr==0:
  - if !empty, pop: sdata={0, full, zeros, entry}.
  - if empty: sdata={1, 0, 30'b0}, with no pointer change.
- OCP READ, maddr==4: sdata=STATUS.
- OCP READ, other addresses: sdata is all ones.
- OCP WRITE and codes 3..7: DVA with sdata=0 and no effect.
- Flags used within a cycle are the pre-edge values:
  - push and pop in the same cycle leave count unchanged;
  - a push while full is rejected even if a pop occurs in the same cycle;
  - a pop while empty reports empty even if a push occurs in the same cycle.
- Flush in the same cycle as a push or pop: flush wins for pointers and count. A same-cycle pop still returns the entry at the pre-flush rd_ptr.
- Reset, including mid-transfer: apb_state=SETUP, apb_pready=0, apb_prdata=0, ocp_sdata=0, ocp_sresp=NULL, pointers=0, count=0, ovf=0. Memory contents are not reset. An in-flight APB transfer is aborted and the master must restart it.

## Timing
- APB: if psel&&penable is first sampled at edge N, state is ENABLE after N. The access commits at edge N+1, and apb_pready is high during the cycle after N+1, for exactly one cycle.
- Minimum APB transfer length is setup plus 3 cycles. Back-to-back APB transfers are accepted.
- A pushed byte is visible to OCP status and pop in the cycle after the commit edge.
- OCP has a fixed response latency of 1 cycle. Accept and issue rate is one command per cycle. A popped slot is writable by APB on the following edge.

## Test plan
- Reset, then an OCP READ at addr 0 -> DVA with sdata=0x8000_0000. An APB read at addr 0 returns 0x8000_0000.
- APB writes 0x11, 0x22, 0x33 to addr 0. Three OCP pops return 0x11, 0x22, 0x33 in order with bit31=0. A fourth pop returns 0x8000_0000.
- Push 256 bytes -> STATUS=0x4000_0100. The 257th push leaves count at 256 and sets ovf (STATUS=0x6000_0100). An APB write of 0x1 to addr 4 clears ovf.
- When full, a same-cycle APB push and OCP pop -> pop returns the oldest byte, the push is dropped, ovf=1, count=255.
- Push and pop 600 bytes with interleaving -> data order is preserved across pointer wrap, and count never exceeds 256.
- With 5 entries queued, APB writes 0x2 to addr 4 -> STATUS=0x8000_0000 and the next pop reports empty. Asserting rst mid-APB-transfer -> pready stays 0 and all outputs read 0 on the next cycle.
